// File: rtl/lbist_counter_pkg.sv
// Shared defaults for the LBIST pattern/cycle counter.
package lbist_counter_pkg;
    localparam int LBIST_CNT_BITS     = 8;
    localparam bit LBIST_CNT_SATURATE = 1'b0;
endpackage

// File: rtl/lbist_counter.sv
// Up-counter with clear/load/increment priority, terminal-count decode and a
// registered overflow pulse; optionally clamps at all-ones instead of wrapping.
module lbist_counter
    import lbist_counter_pkg::*;
#(
    parameter int BITS     = LBIST_CNT_BITS,
    parameter bit SATURATE = LBIST_CNT_SATURATE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    input  logic            load,
    input  logic [0:BITS-1] load_val,
    output logic [0:BITS-1] count,
    output logic            tc,
    output logic            ovf
);

    logic [0:BITS-1] count_d, count_q;
    logic            ovf_d, ovf_q;
    logic            at_max;

    always_comb begin
        at_max  = &count_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc) begin
            // ovf pulses on every increment from all-ones, clamped or not
            ovf_d = at_max;
            if (at_max && SATURATE) count_d = count_q;
            else                    count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = at_max;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_lbist_counter.sv
// Directed plus randomized checks of lbist_counter in wrap and saturate modes
// against an integer reference model.
module tb_lbist_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [0:7] load_val = '0;
    logic [0:7] count_w, count_s;
    logic       tc_w, tc_s, ovf_w, ovf_s;

    int tests  = 0;
    int failed = 0;

    // reference state: plain integers
    int m_w = 0, m_s = 0;
    int o_w = 0, o_s = 0;

    always #5 clk = ~clk;

    lbist_counter #(.BITS(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .inc(inc), .clr(clr), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w)
    );

    lbist_counter #(.BITS(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .inc(inc), .clr(clr), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " count_wrap"}, 32'(count_w), 32'(m_w));
        chk({tag, " tc_wrap"},    32'(tc_w),    32'(m_w == 255));
        chk({tag, " ovf_wrap"},   32'(ovf_w),   32'(o_w));
        chk({tag, " count_sat"},  32'(count_s), 32'(m_s));
        chk({tag, " tc_sat"},     32'(tc_s),    32'(m_s == 255));
        chk({tag, " ovf_sat"},    32'(ovf_s),   32'(o_s));
    endtask

    function automatic void model_edge(input bit i, input bit c, input bit l, input int v);
        if (c) begin
            m_w = 0; m_s = 0; o_w = 0; o_s = 0;
        end else if (l) begin
            m_w = v; m_s = v; o_w = 0; o_s = 0;
        end else if (i) begin
            o_w = (m_w == 255);
            o_s = (m_s == 255);
            m_w = (m_w + 1) % 256;
            m_s = (m_s == 255) ? 255 : m_s + 1;
        end else begin
            o_w = 0; o_s = 0;
        end
    endfunction

    function automatic void model_reset();
        m_w = 0; m_s = 0; o_w = 0; o_s = 0;
    endfunction

    // Inputs change 1 time unit after the edge; checks follow the same edge.
    task automatic step(input string tag, input bit i, input bit c, input bit l, input int v);
        inc = i; clr = c; load = l; load_val = 8'(v);
        @(posedge clk);
        model_edge(i, c, l, v);
        #1;
        check_all(tag);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        // reset state
        #2 check_all("reset");
        @(posedge clk); #1 rst = 1'b0;

        // reset mid-cycle with count = 0x2A, then idle edges
        step("load2a", 0, 0, 1, 8'h2A);
        mid_reset("rst_2a");
        for (int k = 0; k < 5; k++) step("idle", 0, 0, 0, 0);

        // count three, then hold for ten
        for (int k = 0; k < 3; k++) step("cnt3", 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) step("hold3", 0, 0, 0, 0);

        // one edge of inc, then a pulse that spans no edge
        step("single", 1, 0, 0, 0);
        inc = 1'b0;
        #2 inc = 1'b1;
        #2 inc = 1'b0;
        step("glitch", 0, 0, 0, 0);

        // wrap boundary
        step("ldfe", 0, 0, 1, 8'hFE);
        step("wrap1", 1, 0, 0, 0);
        step("wrap2", 1, 0, 0, 0);
        step("wrap3", 0, 0, 0, 0);

        // saturate boundary: three increments from all-ones
        step("ldff", 0, 0, 1, 8'hFF);
        for (int k = 0; k < 3; k++) step("sat", 1, 0, 0, 0);
        step("satidle", 0, 0, 0, 0);

        // async reset while ovf is high
        step("ldff2", 0, 0, 1, 8'hFF);
        step("ovfhi", 1, 0, 0, 0);
        mid_reset("rst_ovf");

        // priority
        step("prio_clr", 1, 1, 1, 8'h55);
        step("prio_ld", 1, 0, 1, 8'h55);
        step("prio_clr2", 0, 1, 1, 8'hAA);

        // randomized traffic, biased towards the all-ones boundary
        for (int k = 0; k < 400; k++) begin
            int r;
            int v;
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 255))
                                            : int'($urandom_range(0, 255));
            if (r < 2)       mid_reset("rnd_rst");
            else if (r < 6)  step("rnd", $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, v);
            else if (r < 16) step("rnd", $urandom_range(0, 1) == 1, 0, 1, v);
            else if (r < 80) step("rnd", 1, 0, 0, v);
            else             step("rnd", 0, 0, 0, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        failed++;
        $display("FAIL timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end

endmodule
